opponent_state_decoder: RTL and testbench

OPPONENT_STATE_DECODER -- requirements
Module: opponent_state_decoder

---
 rtl/opponent_state_decoder.sv | 148 ++++++++++++++
 tb/tb_opponent_state_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/opponent_state_decoder.sv
// opponent_state_decoder
//   Validates 44-bit game words from the opponent link, holds the last
//   accepted opponent state, and tracks link liveness.
//
// Ports:
//   clk_in            system clock
//   rst_in            synchronous active-high reset
//   axiov_in          received-word valid
//   axiod_in[43:0]    received game word
//                     x=[43:33] y=[31:21] dir=[19:11] game=[7:5] reset=[3]
//                     bits 32, 20, 10:8, 4, 2:0 must be zero
//   opp_x_out[10:0]   held opponent x
//   opp_y_out[10:0]   held opponent y
//   opp_dir_out[8:0]  held opponent direction, degrees
//   opp_game_out[2:0] held opponent game status
//   opp_reset_out     one-cycle pulse on a 0->1 edge of the held reset bit
//   update_out        one-cycle pulse when the held state changes
//   link_state_out    0=IDLE, 1=ACTIVE, 2=STALE
//   reject_count_out  saturating count of rejected words
//
// state  | meaning
// IDLE   | no word accepted since reset
// ACTIVE | words arriving; timer counts cycles since the last accept
// STALE  | no accept for STALE_CYCLES cycles; held values kept

module opponent_state_decoder #(
  parameter int STALE_CYCLES = 50_000_000,
  parameter int COORD_MAX    = 1024
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        axiov_in,
  input  logic [43:0] axiod_in,
  output logic [10:0] opp_x_out,
  output logic [10:0] opp_y_out,
  output logic [8:0]  opp_dir_out,
  output logic [2:0]  opp_game_out,
  output logic        opp_reset_out,
  output logic        update_out,
  output logic [1:0]  link_state_out,
  output logic [7:0]  reject_count_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALE  = 2'd2
  } link_t;

  localparam int             CW   = $clog2(STALE_CYCLES + 1);
  localparam logic [CW-1:0]  TC   = CW'(STALE_CYCLES - 1);
  localparam logic [11:0]    CMAX = 12'(COORD_MAX);

  link_t         state;
  logic [CW-1:0] timer;
  logic          have_word;
  logic          held_rst;

  logic [10:0]   w_x;
  logic [10:0]   w_y;
  logic [8:0]    w_dir;
  logic [2:0]    w_game;
  logic          w_rst;
  logic          rsvd_ok;
  logic          sampled;
  logic          fields_ok;
  logic          accept;
  logic          reject;
  logic          changed;
  logic [CW-1:0] timer_inc;
  logic          terminal;

  assign w_x    = axiod_in[43:33];
  assign w_y    = axiod_in[31:21];
  assign w_dir  = axiod_in[19:11];
  assign w_game = axiod_in[7:5];
  assign w_rst  = axiod_in[3];

  assign rsvd_ok = ~|{axiod_in[32], axiod_in[20], axiod_in[10:8],
                      axiod_in[4], axiod_in[2:0]};

  // An all-zero word is link filler: neither accepted nor rejected.
  assign sampled   = axiov_in && (|axiod_in);
  assign fields_ok = rsvd_ok && ({1'b0, w_x} < CMAX) && ({1'b0, w_y} < CMAX)
                     && (w_dir < 9'd360);
  assign accept    = sampled && fields_ok;
  assign reject    = sampled && !fields_ok;

  // The first word after reset always counts as a change.
  assign changed = !have_word || (w_x != opp_x_out) || (w_y != opp_y_out) ||
                   (w_dir != opp_dir_out) || (w_game != opp_game_out) ||
                   (w_rst != held_rst);

  // The timer goes stale on the edge where it would reach STALE_CYCLES-1.
  assign timer_inc = timer + CW'(1);
  assign terminal  = (timer_inc >= TC);

  assign link_state_out = state;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      timer            <= '0;
      have_word        <= 1'b0;
      held_rst         <= 1'b0;
      opp_x_out        <= '0;
      opp_y_out        <= '0;
      opp_dir_out      <= '0;
      opp_game_out     <= '0;
      opp_reset_out    <= 1'b0;
      update_out       <= 1'b0;
      reject_count_out <= '0;
    end else begin
      update_out    <= 1'b0;
      opp_reset_out <= 1'b0;

      if (reject && (reject_count_out != 8'hFF))
        reject_count_out <= reject_count_out + 8'd1;

      if (accept) begin
        // Accept beats a simultaneous timeout.
        opp_x_out     <= w_x;
        opp_y_out     <= w_y;
        opp_dir_out   <= w_dir;
        opp_game_out  <= w_game;
        held_rst      <= w_rst;
        have_word     <= 1'b1;
        update_out    <= changed;
        opp_reset_out <= w_rst && !held_rst;
        state         <= ACTIVE;
        timer         <= '0;
      end else begin
        case (state)
          ACTIVE: begin
            if (terminal) begin
              state <= STALE;
              timer <= '0;
            end else begin
              timer <= timer_inc;
            end
          end
          default: timer <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_opponent_state_decoder.sv
// tb_opponent_state_decoder
//   Directed stimulus with a cycle-level reference model and hand-computed
//   literal expectations for opponent_state_decoder (STALE_CYCLES=16).

module tb_opponent_state_decoder;

  localparam int STALE = 16;
  localparam logic [43:0] RSV_MASK = 44'h00100100717;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        axiov_in;
  logic [43:0] axiod_in;
  logic [10:0] opp_x_out;
  logic [10:0] opp_y_out;
  logic [8:0]  opp_dir_out;
  logic [2:0]  opp_game_out;
  logic        opp_reset_out;
  logic        update_out;
  logic [1:0]  link_state_out;
  logic [7:0]  reject_count_out;

  int errors = 0;
  int checks = 0;

  // model state
  int m_x, m_y, m_d, m_g, m_r, m_rej, m_since;
  bit m_have;
  int e_upd, e_rpl;

  int upd_seen, rpl_seen;

  opponent_state_decoder #(.STALE_CYCLES(STALE), .COORD_MAX(1024)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .axiov_in        (axiov_in),
    .axiod_in        (axiod_in),
    .opp_x_out       (opp_x_out),
    .opp_y_out       (opp_y_out),
    .opp_dir_out     (opp_dir_out),
    .opp_game_out    (opp_game_out),
    .opp_reset_out   (opp_reset_out),
    .update_out      (update_out),
    .link_state_out  (link_state_out),
    .reject_count_out(reject_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [43:0] mk(input int x, input int y, input int d,
                                     input int g, input int r);
    return {x[10:0], 1'b0, y[10:0], 1'b0, d[8:0], 3'b000, g[2:0], 1'b0,
            r[0], 3'b000};
  endfunction

  // Applies one cycle of inputs just after the rising edge.
  task automatic cyc(input logic r, input logic v, input logic [43:0] d);
    @(posedge clk_in);
    #1;
    rst_in   = r;
    axiov_in = v;
    axiod_in = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 44'd0);
  endtask

  function automatic int exp_link();
    if (!m_have) return 0;
    return (m_since >= STALE) ? 2 : 1;
  endfunction

  // Advances the model by the inputs about to be sampled at the next edge.
  task automatic model_step();
    int fx, fy, fd, fg, fr;
    bit ok;
    e_upd = 0;
    e_rpl = 0;
    if (rst_in) begin
      m_x = 0; m_y = 0; m_d = 0; m_g = 0; m_r = 0;
      m_rej = 0; m_since = 0; m_have = 0;
    end else if (axiov_in && axiod_in != 44'd0) begin
      fx = int'(axiod_in[43:33]);
      fy = int'(axiod_in[31:21]);
      fd = int'(axiod_in[19:11]);
      fg = int'(axiod_in[7:5]);
      fr = int'(axiod_in[3]);
      ok = ((axiod_in & RSV_MASK) == 44'd0) && fx < 1024 && fy < 1024 && fd < 360;
      if (ok) begin
        e_upd = (!m_have || fx != m_x || fy != m_y || fd != m_d ||
                 fg != m_g || fr != m_r) ? 1 : 0;
        e_rpl = (fr == 1 && m_r == 0) ? 1 : 0;
        m_x = fx; m_y = fy; m_d = fd; m_g = fg; m_r = fr;
        m_have = 1;
        m_since = 1;
      end else begin
        if (m_rej < 255) m_rej++;
        if (m_since < 1000) m_since++;
      end
    end else begin
      if (m_since < 1000) m_since++;
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    m_x = 0; m_y = 0; m_d = 0; m_g = 0; m_r = 0;
    m_rej = 0; m_since = 0; m_have = 0; e_upd = 0; e_rpl = 0;
    repeat (2) @(posedge clk_in);
    forever begin
      @(negedge clk_in);
      chk("x", int'(opp_x_out), m_x);
      chk("y", int'(opp_y_out), m_y);
      chk("dir", int'(opp_dir_out), m_d);
      chk("game", int'(opp_game_out), m_g);
      chk("update", int'(update_out), e_upd);
      chk("opp_reset", int'(opp_reset_out), e_rpl);
      chk("link", int'(link_state_out), exp_link());
      chk("rejects", int'(reject_count_out), m_rej);
      model_step();
    end
  end

  // Pulse counters for the duplicate-word scenarios.
  initial begin
    upd_seen = 0;
    rpl_seen = 0;
    forever begin
      @(negedge clk_in);
      if (update_out) upd_seen++;
      if (opp_reset_out) rpl_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  logic [43:0] w1, w2, w2r;

  initial begin
    rst_in   = 1'b1;
    axiov_in = 1'b0;
    axiod_in = 44'd0;
    w1  = mk(191, 191, 270, 1, 0);
    w2  = mk(5, 6, 7, 2, 0);
    w2r = mk(5, 6, 7, 2, 1);
    repeat (3) cyc(1'b1, 1'b0, 44'd0);
    cyc(1'b0, 1'b0, 44'd0);
    @(negedge clk_in);
    chk("lit_reset_x", int'(opp_x_out), 0);
    chk("lit_reset_link", int'(link_state_out), 0);
    chk("lit_reset_rej", int'(reject_count_out), 0);

    // accept
    cyc(1'b0, 1'b1, w1);
    idle(1);
    @(negedge clk_in);
    chk("lit_acc_x", int'(opp_x_out), 191);
    chk("lit_acc_y", int'(opp_y_out), 191);
    chk("lit_acc_dir", int'(opp_dir_out), 270);
    chk("lit_acc_game", int'(opp_game_out), 1);
    chk("lit_acc_update", int'(update_out), 1);
    chk("lit_acc_link", int'(link_state_out), 1);
    idle(1);
    @(negedge clk_in);
    chk("lit_acc_update_once", int'(update_out), 0);

    // rejects
    cyc(1'b0, 1'b1, mk(10, 10, 360, 0, 0));
    cyc(1'b0, 1'b1, mk(1024, 5, 5, 0, 0));
    cyc(1'b0, 1'b1, w1 | 44'h4);
    idle(1);
    @(negedge clk_in);
    chk("lit_rej_count", int'(reject_count_out), 3);
    chk("lit_rej_x", int'(opp_x_out), 191);
    chk("lit_rej_update", int'(update_out), 0);
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, mk(0, 0, 400, 0, 0));
    idle(1);
    @(negedge clk_in);
    chk("lit_rej_sat", int'(reject_count_out), 255);
    chk("lit_rej_stale", int'(link_state_out), 2);

    // duplicate words, then reset-bit edge
    idle(1);
    upd_seen = 0; rpl_seen = 0;
    repeat (3) cyc(1'b0, 1'b1, w2);
    idle(3);
    chk("lit_dup_updates", upd_seen, 1);
    upd_seen = 0; rpl_seen = 0;
    repeat (2) cyc(1'b0, 1'b1, w2r);
    idle(3);
    chk("lit_rstbit_pulses", rpl_seen, 1);
    chk("lit_rstbit_updates", upd_seen, 1);

    // timeout
    cyc(1'b0, 1'b1, w1);
    idle(15);
    @(negedge clk_in);
    chk("lit_to_active15", int'(link_state_out), 1);
    idle(1);
    @(negedge clk_in);
    chk("lit_to_stale16", int'(link_state_out), 2);
    chk("lit_to_held_x", int'(opp_x_out), 191);
    chk("lit_to_held_dir", int'(opp_dir_out), 270);
    cyc(1'b0, 1'b1, w2);
    idle(1);
    @(negedge clk_in);
    chk("lit_to_reactive", int'(link_state_out), 1);
    idle(13);
    cyc(1'b0, 1'b1, w1);
    idle(3);
    @(negedge clk_in);
    chk("lit_to_terminal_accept", int'(link_state_out), 1);

    // reset together with a valid word
    cyc(1'b1, 1'b1, w2);
    idle(1);
    @(negedge clk_in);
    chk("lit_rst_x", int'(opp_x_out), 0);
    chk("lit_rst_link", int'(link_state_out), 0);
    chk("lit_rst_update", int'(update_out), 0);
    chk("lit_rst_rej", int'(reject_count_out), 0);

    // first word after reset carries reset=1, then zero words only
    cyc(1'b0, 1'b1, w2r);
    cyc(1'b0, 1'b1, 44'd0);
    @(negedge clk_in);
    chk("lit_first_rst_pulse", int'(opp_reset_out), 1);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 44'd0);
    @(negedge clk_in);
    chk("lit_zero_stale", int'(link_state_out), 2);
    chk("lit_zero_rej", int'(reject_count_out), 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
